wfg_stim_mem: RTL and testbench
===============================

WFG_STIM_MEM -- requirements
Module: wfg_stim_mem

Interface
REQ-001 Parameter AXIS_DATA_WIDTH SHALL default to 32 and set the width of stream data and memory read data.
REQ-002 Parameter MEM_ADDR_WIDTH SHALL default to 16 and set the width of memory address and address configuration.
REQ-003 clk  in  1  system clock; the block SHALL use one clock, with all state on its rising edge.
REQ-004 rst  in  1  reset; synchronous and active-high.
REQ-005 ctrl_en_q_i  in  1  stimulus enable.
REQ-006 cfg_start_q_i  in  MEM_ADDR_WIDTH  first word address.
REQ-007 cfg_end_q_i  in  MEM_ADDR_WIDTH  last permitted word address (inclusive).
REQ-008 cfg_inc_q_i  in  8  address increment per word; 0 SHALL be treated as 1.
REQ-009 cfg_gain_q_i  in  16  unsigned gain, 8.8 fixed point (0x0100 = 1.0).
REQ-010 mem_req_o  out  1  memory read request.
REQ-011 mem_addr_o  out  MEM_ADDR_WIDTH  memory read address.
REQ-012 mem_ack_i  in  1  read acknowledge; mem_data_i is valid in this cycle.
REQ-013 mem_data_i  in  AXIS_DATA_WIDTH  memory read data.
REQ-014 wfg_axis_tready_i  in  1  downstream ready (SPI driver).
REQ-015 wfg_axis_tvalid_o  out  1  stream valid.
REQ-016 wfg_axis_tlast_o  out  1  last word of the address sweep.
REQ-017 wfg_axis_tdata_o  out  AXIS_DATA_WIDTH  scaled sample.

Function
REQ-018 FSM states SHALL be ST_IDLE, ST_FETCH and ST_OUTPUT.
REQ-019 ST_IDLE: with ctrl_en_q_i=1, the block SHALL latch start, end, inc and gain, set addr=start and enter ST_FETCH next cycle.
REQ-020 ST_FETCH: mem_req_o=1 and mem_addr_o=addr SHALL be held stable until mem_ack_i; on ack, the block SHALL register the scaled data and enter ST_OUTPUT.
REQ-021 Scaling: tdata = (mem_data_i * gain) >> 8, full-width product, saturated to all-ones on overflow of AXIS_DATA_WIDTH.
REQ-022 tlast SHALL be registered with the data and is 1 iff addr+inc > end or the sum overflows MEM_ADDR_WIDTH.
REQ-023 ST_OUTPUT: tvalid_o=1; tdata/tlast SHALL be stable until the tvalid&tready cycle.
REQ-024 On handshake, the block SHALL set addr to start if tlast was 1, else to addr+inc, and enter ST_FETCH (ctrl_en_q_i=1) or ST_IDLE (ctrl_en_q_i=0).
REQ-025 Deasserting ctrl_en_q_i in ST_FETCH or ST_OUTPUT SHALL NOT abort a pending mem or stream handshake; the block SHALL stop only after that handshake completes.
REQ-026 If start > end, each sweep SHALL consist of a single word at start with tlast=1.
REQ-027 Minimum latency: ack at cycle N -> tvalid at N+1; handshake at M -> mem_req at M+1.
REQ-028 Configuration changes outside ST_IDLE SHALL have no effect until the next ST_IDLE exit.
REQ-029 mem_req_o and wfg_axis_tvalid_o SHALL never be asserted in the same cycle.

Reset
REQ-030 rst=1 SHALL force ST_IDLE, addr=0, and all outputs (mem_req_o, mem_addr_o, tvalid, tlast, tdata) to 0 in the next cycle, including mid-handshake.
REQ-031 Latched configuration SHALL reset to start=0, end=0, inc=1, gain=0x0100.

Structure
REQ-032 The state enum and the gain fraction width constant (8) SHALL reside in shared package wfg_stim_mem_pkg.
REQ-033 The saturating multiply-shift SHALL be a sub-module named wfg_stim_mem_scale (purely combinational, parameterised by width).

Verification
REQ-034 start=0, end=3, inc=1, gain=0x0100, tready=1, memory data = address -> stream 0,1,2,3(tlast),0,... with addresses 0,1,2,3,0.
REQ-035 gain=0x0200, data 0x9000_0000 -> tdata=0xFFFF_FFFF (saturated); data 0x10 -> 0x20.
REQ-036 tready held 0 for 5 cycles in ST_OUTPUT -> tvalid, tdata and tlast are stable; no mem_req_o is asserted.
REQ-037 start=0xFFF0, end=0xFFFF, inc=0x20 -> single word at 0xFFF0 with tlast=1, then repeats at 0xFFF0.
REQ-038 ctrl_en_q_i drops while mem_ack_i is delayed 3 cycles -> ack is accepted, one word is output, then ST_IDLE.
REQ-039 rst asserted during ST_OUTPUT -> next cycle tvalid=0, mem_req_o=0, and a later enable restarts at cfg_start_q_i.

Source files
------------

// File: rtl/wfg_stim_mem_pkg.sv
// Shared types and constants for the stimulus-memory waveform generator.
package wfg_stim_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_OUTPUT = 2'd2
  } state_t;

  // Gain is unsigned 8.8 fixed point
  localparam int GAIN_W      = 16;
  localparam int GAIN_FRAC_W = 8;
  localparam int INC_W       = 8;

  localparam logic [GAIN_W-1:0] GAIN_UNITY = 16'h0100;

endpackage

// File: rtl/wfg_stim_mem_if.sv
// Memory read port plus AXI-Stream output of the stimulus-memory generator.
interface wfg_stim_mem_if #(
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int MEM_ADDR_WIDTH  = 16
);

  logic                       mem_req_o;
  logic [MEM_ADDR_WIDTH-1:0]  mem_addr_o;
  logic                       mem_ack_i;
  logic [AXIS_DATA_WIDTH-1:0] mem_data_i;

  logic                       wfg_axis_tready_i;
  logic                       wfg_axis_tvalid_o;
  logic                       wfg_axis_tlast_o;
  logic [AXIS_DATA_WIDTH-1:0] wfg_axis_tdata_o;

  // Generator side: issues reads, produces the stream
  modport master (
    output mem_req_o,
    output mem_addr_o,
    input  mem_ack_i,
    input  mem_data_i,
    input  wfg_axis_tready_i,
    output wfg_axis_tvalid_o,
    output wfg_axis_tlast_o,
    output wfg_axis_tdata_o
  );

  // Environment side: memory plus stream consumer
  modport slave (
    input  mem_req_o,
    input  mem_addr_o,
    output mem_ack_i,
    output mem_data_i,
    output wfg_axis_tready_i,
    input  wfg_axis_tvalid_o,
    input  wfg_axis_tlast_o,
    input  wfg_axis_tdata_o
  );

endinterface

// File: rtl/wfg_stim_mem_scale.sv
// Combinational unsigned gain: (data * gain) >> FRAC_W, saturating to all-ones.
module wfg_stim_mem_scale
  import wfg_stim_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int G_W    = GAIN_W,
  parameter int FRAC_W = GAIN_FRAC_W
) (
  input  logic [DATA_W-1:0] data,
  input  logic [G_W-1:0]    gain,
  output logic [DATA_W-1:0] scaled
);

  localparam int PROD_W  = DATA_W + G_W;
  localparam int SHIFT_W = PROD_W - FRAC_W;

  // Any bit above DATA_W after the fraction is dropped means overflow
  function automatic logic [DATA_W-1:0] sat_shift(input logic [PROD_W-1:0] prod);
    logic [SHIFT_W-1:0] shifted;
    shifted = prod[PROD_W-1:FRAC_W];
    if (|shifted[SHIFT_W-1:DATA_W]) begin
      return '1;
    end
    return shifted[DATA_W-1:0];
  endfunction

  logic [PROD_W-1:0] product;

  assign product = PROD_W'(data) * PROD_W'(gain);
  assign scaled  = sat_shift(product);

endmodule

// File: rtl/wfg_stim_mem.sv
// Sweeps a memory address range, scales each read word and streams it out.
module wfg_stim_mem
  import wfg_stim_mem_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int MEM_ADDR_WIDTH  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ctrl_en_q_i,
  input  logic [MEM_ADDR_WIDTH-1:0] cfg_start_q_i,
  input  logic [MEM_ADDR_WIDTH-1:0] cfg_end_q_i,
  input  logic [INC_W-1:0]          cfg_inc_q_i,
  input  logic [GAIN_W-1:0]         cfg_gain_q_i,
  wfg_stim_mem_if.master            bus
);

  state_t state;
  state_t state_next;

  logic [MEM_ADDR_WIDTH-1:0]  addr;
  logic [MEM_ADDR_WIDTH-1:0]  start_q;
  logic [MEM_ADDR_WIDTH-1:0]  end_q;
  logic [INC_W-1:0]           inc_q;
  logic [GAIN_W-1:0]          gain_q;

  logic [AXIS_DATA_WIDTH-1:0] tdata_p1;
  logic                       tlast_p1;
  logic [AXIS_DATA_WIDTH-1:0] scaled;

  logic [MEM_ADDR_WIDTH:0]    addr_sum;
  logic                       last_word;

  logic fetch_done;
  logic out_done;

  assign fetch_done = (state == ST_FETCH)  && bus.mem_ack_i;
  assign out_done   = (state == ST_OUTPUT) && bus.wfg_axis_tready_i;

  // Carry bit catches address wrap; start > end also lands here since addr+inc > end
  assign addr_sum  = {1'b0, addr} + (MEM_ADDR_WIDTH + 1)'(inc_q);
  assign last_word = addr_sum[MEM_ADDR_WIDTH] || (addr_sum[MEM_ADDR_WIDTH-1:0] > end_q);

  wfg_stim_mem_scale #(
    .DATA_W (AXIS_DATA_WIDTH),
    .G_W    (GAIN_W),
    .FRAC_W (GAIN_FRAC_W)
  ) u_scale (
    .data   (bus.mem_data_i),
    .gain   (gain_q),
    .scaled (scaled)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; enable is only looked at between handshakes
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:   if (ctrl_en_q_i) state_next = ST_FETCH;
      ST_FETCH:  if (bus.mem_ack_i) state_next = ST_OUTPUT;
      ST_OUTPUT: if (bus.wfg_axis_tready_i) state_next = ctrl_en_q_i ? ST_FETCH : ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Configuration latch, address walk and output data register
  always_ff @(posedge clk) begin
    if (rst) begin
      addr     <= '0;
      start_q  <= '0;
      end_q    <= '0;
      inc_q    <= INC_W'(1);
      gain_q   <= GAIN_UNITY;
      tdata_p1 <= '0;
      tlast_p1 <= 1'b0;
    end else begin
      if (state == ST_IDLE && ctrl_en_q_i) begin
        start_q <= cfg_start_q_i;
        end_q   <= cfg_end_q_i;
        inc_q   <= (cfg_inc_q_i == '0) ? INC_W'(1) : cfg_inc_q_i;
        gain_q  <= cfg_gain_q_i;
        addr    <= cfg_start_q_i;
      end
      if (fetch_done) begin
        tdata_p1 <= scaled;
        tlast_p1 <= last_word;
      end
      if (out_done) begin
        addr <= tlast_p1 ? start_q : addr_sum[MEM_ADDR_WIDTH-1:0];
      end
    end
  end

  // Outputs decoded from state; request and valid are mutually exclusive by construction
  always_comb begin
    bus.mem_req_o         = (state == ST_FETCH);
    bus.mem_addr_o        = addr;
    bus.wfg_axis_tvalid_o = (state == ST_OUTPUT);
    bus.wfg_axis_tlast_o  = tlast_p1;
    bus.wfg_axis_tdata_o  = tdata_p1;
  end

endmodule

// File: tb/tb_wfg_stim_mem.sv
// Self-checking bench for wfg_stim_mem: directed sweeps plus randomized configurations.
module tb_wfg_stim_mem;

  localparam int DW = 32;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [AW-1:0] cfg_start;
  logic [AW-1:0] cfg_end;
  logic [7:0]    cfg_inc;
  logic [15:0]   cfg_gain;

  int checks = 0;
  int errors = 0;

  // Reference model state: latched configuration and the next expected address
  int m_start, m_end, m_inc, m_gain, m_addr;

  bit overlap_seen = 1'b0;

  always #5 clk = ~clk;

  wfg_stim_mem_if #(.AXIS_DATA_WIDTH(DW), .MEM_ADDR_WIDTH(AW)) bus ();

  wfg_stim_mem #(.AXIS_DATA_WIDTH(DW), .MEM_ADDR_WIDTH(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .ctrl_en_q_i   (en),
    .cfg_start_q_i (cfg_start),
    .cfg_end_q_i   (cfg_end),
    .cfg_inc_q_i   (cfg_inc),
    .cfg_gain_q_i  (cfg_gain),
    .bus           (bus.master)
  );

  always @(negedge clk) begin
    if (bus.mem_req_o === 1'b1 && bus.wfg_axis_tvalid_o === 1'b1) overlap_seen <= 1'b1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scaled value from the arithmetic rule: multiply, divide by 256, clamp to 32 bits
  function automatic logic [31:0] exp_scale(input longint unsigned d, input longint unsigned g);
    longint unsigned v;
    v = (d * g) / 256;
    if (v > 64'h0000_0000_FFFF_FFFF) v = 64'h0000_0000_FFFF_FFFF;
    return 32'(v);
  endfunction

  task automatic enable(input int s, input int e, input int i, input int g);
    cfg_start = AW'(s);
    cfg_end   = AW'(e);
    cfg_inc   = 8'(i);
    cfg_gain  = 16'(g);
    en        = 1'b1;
    step();
    m_start = s;
    m_end   = e;
    m_inc   = (i == 0) ? 1 : i;
    m_gain  = g;
    m_addr  = s;
  endtask

  // One full word: read request, delayed ack, stream stall, handshake
  task automatic word(input logic [31:0] data, input int ack_dly, input int rdy_dly);
    int          n;
    logic        exp_last;
    logic [31:0] exp_data;
    n = 0;
    while (bus.mem_req_o !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("mem_req", 64'(bus.mem_req_o), 64'(1));
    chk("mem_addr", 64'(bus.mem_addr_o), 64'(m_addr));
    for (int k = 0; k < ack_dly; k++) begin
      step();
      chk("req_hold", 64'({bus.mem_req_o, bus.wfg_axis_tvalid_o, bus.mem_addr_o}),
          64'({1'b1, 1'b0, AW'(m_addr)}));
    end
    bus.mem_ack_i  = 1'b1;
    bus.mem_data_i = data;
    step();
    bus.mem_ack_i  = 1'b0;
    bus.mem_data_i = $urandom;
    exp_data = exp_scale(longint'(data), longint'(m_gain));
    exp_last = (m_addr + m_inc > m_end);
    chk("tvalid", 64'(bus.wfg_axis_tvalid_o), 64'(1));
    chk("req_off", 64'(bus.mem_req_o), 64'(0));
    chk("tdata", 64'(bus.wfg_axis_tdata_o), 64'(exp_data));
    chk("tlast", 64'(bus.wfg_axis_tlast_o), 64'(exp_last));
    for (int k = 0; k < rdy_dly; k++) begin
      step();
      chk("stall", 64'({bus.wfg_axis_tvalid_o, bus.mem_req_o, bus.wfg_axis_tlast_o, bus.wfg_axis_tdata_o}),
          64'({1'b1, 1'b0, exp_last, exp_data}));
    end
    bus.wfg_axis_tready_i = 1'b1;
    step();
    bus.wfg_axis_tready_i = 1'b0;
    m_addr = exp_last ? m_start : m_addr + m_inc;
    if (en) begin
      chk("refetch", 64'({bus.mem_req_o, bus.wfg_axis_tvalid_o, bus.mem_addr_o}),
          64'({1'b1, 1'b0, AW'(m_addr)}));
    end else begin
      chk("stop", 64'({bus.mem_req_o, bus.wfg_axis_tvalid_o}), 64'(0));
    end
  endtask

  task automatic idle_check(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      step();
      chk("idle", 64'({bus.mem_req_o, bus.wfg_axis_tvalid_o}), 64'(0));
    end
  endtask

  initial begin
    int n;
    int s, e, i, g, nw;
    rst = 1'b1;
    en = 1'b0;
    cfg_start = '0;
    cfg_end = '0;
    cfg_inc = '0;
    cfg_gain = '0;
    bus.mem_ack_i = 1'b0;
    bus.mem_data_i = '0;
    bus.wfg_axis_tready_i = 1'b0;

    // Reset state
    step();
    step();
    rst = 1'b0;
    chk("rst_req", 64'(bus.mem_req_o), 64'(0));
    chk("rst_addr", 64'(bus.mem_addr_o), 64'(0));
    chk("rst_tvalid", 64'(bus.wfg_axis_tvalid_o), 64'(0));
    chk("rst_tlast", 64'(bus.wfg_axis_tlast_o), 64'(0));
    chk("rst_tdata", 64'(bus.wfg_axis_tdata_o), 64'(0));
    idle_check(2);

    // Basic sweep 0..3 with data equal to address, wrapping back to 0
    enable(0, 3, 1, 16'h0100);
    for (int w = 0; w < 4; w++) word(32'(m_addr), 0, 0);
    en = 1'b0;
    word(32'(m_addr), 0, 0);
    idle_check(3);

    // Gain 2.0: saturating case followed by an in-range case
    enable(16'h10, 16'h20, 1, 16'h0200);
    word(32'h9000_0000, 1, 0);
    en = 1'b0;
    word(32'h0000_0010, 0, 0);
    idle_check(2);

    // Downstream stall of five cycles
    enable(0, 1, 1, 16'h0180);
    word($urandom, 0, 5);
    en = 1'b0;
    word($urandom, 2, 0);

    // Address wrap past the top of memory: single-word sweep
    enable(16'hFFF0, 16'hFFFF, 8'h20, 16'h0100);
    word($urandom, 0, 0);
    word($urandom, 1, 1);
    en = 1'b0;
    word($urandom, 0, 0);

    // start beyond end: single-word sweep at start
    enable(5, 2, 3, 16'h0100);
    word($urandom, 0, 0);
    en = 1'b0;
    word($urandom, 0, 0);

    // Zero increment acts as one; config changes mid-run are ignored
    enable(0, 2, 0, 16'h0100);
    cfg_start = 16'd9;
    cfg_end = 16'd100;
    cfg_inc = 8'd5;
    cfg_gain = 16'h0300;
    for (int w = 0; w < 3; w++) word($urandom, 0, 0);
    en = 1'b0;
    word($urandom, 0, 0);

    // Enable drops while the memory ack is held off three cycles
    enable(3, 6, 2, 16'h0100);
    word($urandom, 0, 0);
    en = 1'b0;
    word($urandom, 3, 0);
    idle_check(4);

    // Randomized configurations and delays
    for (int r = 0; r < 6; r++) begin
      s = int'($urandom_range(0, 40));
      e = (r == 2) ? s - 1 : s + int'($urandom_range(0, 20));
      if (e < 0) e = 0;
      i = int'($urandom_range(0, 6));
      g = int'($urandom_range(0, 16'hFFFF));
      nw = int'($urandom_range(2, 8));
      enable(s, e, i, g);
      for (int w = 0; w < nw; w++) begin
        if (w == nw - 1) en = 1'b0;
        word($urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end
    end

    // Reset while a word is waiting for the stream handshake
    enable(20, 30, 1, 16'h0100);
    n = 0;
    while (bus.mem_req_o !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    bus.mem_ack_i = 1'b1;
    bus.mem_data_i = 32'h1234_5678;
    step();
    bus.mem_ack_i = 1'b0;
    chk("pre_rst_tvalid", 64'(bus.wfg_axis_tvalid_o), 64'(1));
    rst = 1'b1;
    step();
    chk("mid_rst", 64'({bus.wfg_axis_tvalid_o, bus.mem_req_o, bus.wfg_axis_tlast_o, bus.wfg_axis_tdata_o}), 64'(0));
    chk("mid_rst_addr", 64'(bus.mem_addr_o), 64'(0));
    rst = 1'b0;
    enable(7, 9, 1, 16'h0100);
    word(32'd77, 0, 0);
    en = 1'b0;
    word(32'd78, 0, 0);
    idle_check(2);

    chk("no_overlap", 64'(overlap_seen), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
